// File: rtl/mux4_scan_ctrl.sv
// mux4_scan_ctrl: sequencer that scans a 4-bit word through an external mux4_1 and serializes the result
// Ports:
//    clk            rising-edge clock
//    rst            asynchronous active-high reset
//    load_in        scan request, accepted only while ready_out=1
//    data_in        word to scan, latched on the accepting edge
//    ready_out      high only in IDLE
//    mux_data_out   registered copy of the accepted word (mux data input)
//    mux_sel_out    registered select (mux select input)
//    mux_y_in       mux output, combinational from mux_data_out/mux_sel_out
//    ser_valid_out  one-cycle strobe per sampled bit
//    ser_bit_out    sampled mux_y_in, valid with ser_valid_out
//    capt_out       rebuilt word, bit index = select at sample time
//    done_out       one-cycle pulse after the fourth sample
//    err_out        rebuilt word differs from loaded word, valid with done_out
// Parameters: DWELL cycles per select value (>=1), MSB_FIRST selects 3..0 order.
// Optional feature: define MUX4_SCAN_CHECK_EN to build the err_out comparator; otherwise err_out=0.
module mux4_scan_ctrl #(
   parameter int DWELL     = 1,
   parameter int MSB_FIRST = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_in,
   input  logic [3:0] data_in,
   output logic       ready_out,
   output logic [3:0] mux_data_out,
   output logic [1:0] mux_sel_out,
   input  logic       mux_y_in,
   output logic       ser_valid_out,
   output logic       ser_bit_out,
   output logic [3:0] capt_out,
   output logic       done_out,
   output logic       err_out
);
   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [1:0] SEL_FIRST = (MSB_FIRST != 0) ? 2'd3 : 2'd0;
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   state_t state, state_nxt;
   logic [CW-1:0] cnt;
   logic [1:0] step;
   logic accept, sample, last;
   logic [3:0] capt_nxt;
   assign accept = (state == IDLE) && load_in;
   assign sample = (state == SCAN) && (cnt == CW'(DWELL - 1));
   assign last = sample && (step == 2'd3);
   assign ready_out = (state == IDLE);
   assign done_out = (state == DONE);
   // captured word including the bit being sampled this cycle
   always_comb begin
      capt_nxt = capt_out;
      capt_nxt[mux_sel_out] = mux_y_in;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: state_nxt = load_in ? SCAN : IDLE;
         SCAN: state_nxt = last ? DONE : SCAN;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         mux_data_out <= '0;
         mux_sel_out <= '0;
         ser_valid_out <= 1'b0;
         ser_bit_out <= 1'b0;
         capt_out <= '0;
         cnt <= '0;
         step <= '0;
      end else begin
         ser_valid_out <= sample;
         if (accept) begin
            mux_data_out <= data_in;
            mux_sel_out <= SEL_FIRST;
            capt_out <= '0;
            cnt <= '0;
            step <= '0;
         end else if (state == SCAN) begin
            cnt <= sample ? '0 : cnt + 1'b1;
            if (sample) begin
               capt_out <= capt_nxt;
               ser_bit_out <= mux_y_in;
               step <= step + 1'b1;
               // select stays on its final value after the last sample; no wrap
               if (step != 2'd3)
                  mux_sel_out <= (MSB_FIRST != 0) ? mux_sel_out - 1'b1 : mux_sel_out + 1'b1;
            end
         end
      end
`ifdef MUX4_SCAN_CHECK_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) err_out <= 1'b0;
      else if (accept) err_out <= 1'b0;
      else if (last) err_out <= (capt_nxt != mux_data_out);
`else
   assign err_out = 1'b0;
`endif
endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// tb_mux4_scan_ctrl: randomized self-checking bench for mux4_scan_ctrl in three configurations
module tb_mux4_scan_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   logic load[3], ready[3], y[3], sv[3], sb[3], done[3], err[3], stuck[3];
   logic [3:0] din[3], mdata[3], capt[3];
   logic [1:0] msel[3];
   int total = 0, bad = 0;
   bit chk_en;
   // instance 0: DWELL=1 LSB-first, 1: DWELL=1 MSB-first, 2: DWELL=3 LSB-first
   for (genvar g = 0; g < 3; g++) begin : gen_dut
      assign y[g] = stuck[g] ? 1'b0 : mdata[g][msel[g]];
      mux4_scan_ctrl #(.DWELL(g == 2 ? 3 : 1), .MSB_FIRST(g == 1 ? 1 : 0)) u_dut (
         .clk(clk), .rst(rst), .load_in(load[g]), .data_in(din[g]), .ready_out(ready[g]),
         .mux_data_out(mdata[g]), .mux_sel_out(msel[g]), .mux_y_in(y[g]),
         .ser_valid_out(sv[g]), .ser_bit_out(sb[g]), .capt_out(capt[g]),
         .done_out(done[g]), .err_out(err[g]));
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask
   task automatic check_idle(input int i, input string tag);
      check({tag, "_ready"}, ready[i], 1);
      check({tag, "_mdata"}, mdata[i], 0);
      check({tag, "_msel"}, msel[i], 0);
      check({tag, "_sv"}, sv[i], 0);
      check({tag, "_sb"}, sb[i], 0);
      check({tag, "_capt"}, capt[i], 0);
      check({tag, "_done"}, done[i], 0);
      check({tag, "_err"}, err[i], 0);
   endtask
   task automatic start(input int i, input logic [3:0] w);
      @(negedge clk);
      check("ready_pre", ready[i], 1);
      load[i] = 1'b1;
      din[i] = w;
      @(posedge clk);
      #1;
      load[i] = 1'b0;
      din[i] = 4'($urandom);
   endtask
   task automatic scan(input int i, input logic [3:0] w, input bit st, input bit poke);
      int d, order[4], j;
      logic [3:0] cap;
      bit exp_sv;
      d = (i == 2) ? 3 : 1;
      for (int k = 0; k < 4; k++) order[k] = (i == 1) ? 3 - k : k;
      cap = st ? 4'd0 : w;
      stuck[i] = st;
      start(i, w);
      for (int c = 1; c <= 4 * d + 2; c++) begin
         @(negedge clk);
         exp_sv = (c >= d + 1) && (c <= 4 * d + 1) && ((c - 1) % d == 0);
         check("ser_valid", sv[i], exp_sv);
         if (exp_sv) begin
            j = (c - 1) / d - 1;
            check("ser_bit", sb[i], cap[order[j]]);
         end
         check("done", done[i], c == 4 * d + 1);
         check("ready", ready[i], c == 4 * d + 2);
         if (c <= 4 * d + 1) begin
            j = (c - 1) / d;
            check("sel", msel[i], order[j > 3 ? 3 : j]);
            check("mdata", mdata[i], w);
         end
         if (c >= 4 * d + 1) begin
            check("capt", capt[i], cap);
            check("err", err[i], chk_en && (cap != w));
         end
         if (poke && c == 2) begin
            load[i] = 1'b1;
            din[i] = 4'($urandom);
         end
         if (poke && c == 3) load[i] = 1'b0;
      end
      stuck[i] = 1'b0;
   endtask
   task automatic reset_mid(input int i, input logic [3:0] w);
      int d;
      d = (i == 2) ? 3 : 1;
      start(i, w);
      for (int c = 1; c <= 2 * d + 1; c++) @(negedge clk);
      check("rm_2nd_strobe", sv[i], 1);
      #2 rst = 1'b1;
      #1 check_idle(i, "rm");
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("rm_no_done", done[i], 0);
         check("rm_ready", ready[i], 1);
      end
   endtask
   initial begin
`ifdef MUX4_SCAN_CHECK_EN
      chk_en = 1'b1;
`else
      chk_en = 1'b0;
`endif
      for (int i = 0; i < 3; i++) begin
         load[i] = 1'b0;
         din[i] = 4'd0;
         stuck[i] = 1'b0;
      end
      #12;
      for (int i = 0; i < 3; i++) check_idle(i, "reset");
      @(negedge clk);
      rst = 1'b0;
      scan(0, 4'b0101, 1'b0, 1'b0);
      scan(1, 4'b0011, 1'b0, 1'b0);
      scan(2, 4'b1001, 1'b0, 1'b0);
      scan(0, 4'b1111, 1'b1, 1'b0);
      scan(0, 4'b0110, 1'b0, 1'b1);
      reset_mid(0, 4'b1100);
      scan(0, 4'b1011, 1'b0, 1'b0);
      reset_mid(2, 4'b0111);
      scan(2, 4'b0100, 1'b0, 1'b1);
      repeat (40) scan($urandom_range(0, 2), 4'($urandom), $urandom_range(0, 5) == 0, 1'($urandom));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
